uop_mem_access: RTL and testbench
=================================

# uop_mem_access

Memory access stage directly downstream of the micro-op execute stage. It owns the memory address register (MAR), accepts one memory command per issued request, and runs it on the 8-bit external bus as one or two byte beats, little-endian. While a command is in flight it raises `stop` back to the execute stage, freezing issue. Read data returns as a 16-bit word tagged with the issuing context.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `a_rst`  in  1  reset, asynchronous, active-low.
- `mar_wr`  in  1  load MAR from `mar_in` this cycle.
- `mar_in`  in  16  new MAR value (ALU result).
- `mem_rq`  in  1  issue a memory command this cycle.
- `mem_rq_cmd`  in  1  0 = read, 1 = write.
- `mem_rq_width`  in  1  0 = byte, 1 = word.
- `main_ex_mem`  in  1  context tag of the request; echoed on completion.
- `wr_data`  in  16  store data; bits [7:0] for byte, full word for word.
- `bus_ack`  in  1  external bus completes the current beat.
- `bus_rdata`  in  8  read byte, valid with `bus_ack`.
- `bus_req`  out  1  beat request.
- `bus_we`  out  1  beat is a write.
- `bus_addr`  out  16  beat address.
- `bus_wdata`  out  8  beat write byte.
- `stop`  out  1  stall to execute stage; command in flight.
- `done`  out  1  one-cycle pulse when a command completes.
- `rd_valid`  out  1  one-cycle pulse when read data is ready.
- `rd_data`  out  16  read result; held until the next read completes.
- `rd_tag`  out  1  `main_ex_mem` captured at issue.

## Operation
- Registers: `mar`, plus per-command `addr`, `cmd`, `width`, `wdata`, `tag`, `lo_byte`.
- `mar_wr` loads `mar` in any state. It does not affect a command already in flight.
- States:
  - IDLE: `bus_req` = 0, `stop` = 0. If `mem_rq` = 1, capture the command and go to BEAT0.
  - Capture rule: `addr` = `mar_wr ? mar_in : mar` (same-cycle bypass), plus cmd, width, `wdata`, and tag.
  - BEAT0: `bus_req` = 1, `bus_addr` = `addr`, `bus_we` = cmd, `bus_wdata` = `wdata[7:0]`.
  - BEAT0 on `bus_ack`: capture `bus_rdata` into `lo_byte`. If word, go to BEAT1; otherwise finish and go to IDLE.
  - BEAT1: `bus_req` = 1, `bus_addr` = `addr + 1` (16-bit wrap, 16'hFFFF → 16'h0000), `bus_wdata` = `wdata[15:8]`.
  - BEAT1 on `bus_ack`: finish and go to IDLE.
- Finish:
  - `done` pulses the next cycle.
  - For a read, `rd_valid` pulses the same cycle, with `rd_data` = {hi, lo} for a word or {8'h00, lo} for a byte, and `rd_tag` = captured tag.
- `stop` = (state != IDLE). It is Moore, from a register, so there is no combinational path from `mem_rq`.
- `mem_rq` while busy is a protocol violation. It is ignored, and state is unchanged.
- Bus outputs hold stable while `bus_req` = 1 and `bus_ack` = 0 (wait states, unbounded).

## Timing
- Reset values (asserted asynchronously):
  - State IDLE.
  - `mar`, `addr`, `rd_data` = 0; `rd_tag` = 0.
  - `bus_req`, `bus_we`, `stop`, `done`, `rd_valid` = 0.
  - `bus_addr`, `bus_wdata` = 0.
- Reset mid-command aborts it: `bus_req` drops immediately, and no `done` is produced.
- Request in cycle N, zero-wait ack:
  - `bus_req` and `stop` high in N+1.
  - Byte: `done`/`rd_valid` in N+2, `stop` low in N+2.
  - Word: BEAT1 in N+2, `done` in N+3.
- Each wait cycle (`bus_ack` = 0) adds one cycle.
- `bus_ack` outside BEAT0/BEAT1 is ignored.
- Back-to-back: a new `mem_rq` is accepted in the cycle `done` pulses (state is IDLE).

## Structure
- Shared package `core_pkg`:
  - State encoding `MA_IDLE` / `MA_BEAT0` / `MA_BEAT1` (2 bits).
  - `MEM_CMD_READ` = 0, `MEM_CMD_WRITE` = 1.
  - `MEM_W_BYTE` = 0, `MEM_W_WORD` = 1.
- Single module, no sub-module; the datapath is small and tightly coupled to the FSM.

## Test plan
- Reset mid-BEAT1 of a word read: all outputs at reset values, IDLE, no `done` afterwards.
- `mar_wr`+`mar_in` = 16'h1234, then byte read with `bus_rdata` = 8'hAB, zero-wait → `bus_addr` 16'h1234, `rd_data` 16'h00AB, `rd_valid`+`done` in N+2, `stop` high only in N+1.
- Word write, same cycle as `mar_wr` with `mar_in` = 16'hFFFF, `wr_data` = 16'hBEEF → beats (16'hFFFF, 8'hEF) then (16'h0000, 8'hBE), `bus_we` = 1, no `rd_valid`.
- Word read at 16'h2000, 3 wait cycles per beat, bytes 8'h34/8'h12, tag 1 → `rd_data` 16'h1234, `rd_tag` 1, outputs stable while waiting, `done` in N+9.
- `mem_rq` pulsed while `stop` = 1, and `mar_wr` to 16'h5555 during BEAT0 → in-flight address unchanged, request ignored, `mar` = 16'h5555 for the next command.
- Back-to-back byte reads with `mem_rq` in the `done` cycle → second `bus_req` the following cycle, no lost or duplicated `done`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the micro-op pipeline: memory-access FSM state
// encoding, memory command/width codes and the beat address helper.
package core_pkg;

    typedef enum logic [1:0] {
        MA_IDLE  = 2'd0,
        MA_BEAT0 = 2'd1,
        MA_BEAT1 = 2'd2
    } ma_state_e;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    localparam logic MEM_W_BYTE = 1'b0;
    localparam logic MEM_W_WORD = 1'b1;

    // Address of the high byte of a little-endian word; wraps at 16 bits.
    function automatic logic [15:0] ma_next_addr(input logic [15:0] addr);
        return addr + 16'd1;
    endfunction

endpackage

// File: rtl/uop_mem_access.sv
// Memory access stage: owns the MAR, runs one read/write command at a time on
// the 8-bit external bus as one or two little-endian byte beats, stalls the
// execute stage while busy and returns read data tagged with its context.
module uop_mem_access
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        a_rst,
    input  logic        mar_wr,
    input  logic [15:0] mar_in,
    input  logic        mem_rq,
    input  logic        mem_rq_cmd,
    input  logic        mem_rq_width,
    input  logic        main_ex_mem,
    input  logic [15:0] wr_data,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        stop,
    output logic        done,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_tag
);

    ma_state_e   state_r;
    ma_state_e   state_next_s;

    logic [15:0] mar_r;
    logic [15:0] addr_r;
    logic        cmd_r;
    logic        width_r;
    logic [7:0]  wdata_hi_r;
    logic        tag_r;
    logic [7:0]  lo_byte_r;

    logic        bus_req_r;
    logic        bus_we_r;
    logic [15:0] bus_addr_r;
    logic [7:0]  bus_wdata_r;
    logic        stop_r;
    logic        done_r;
    logic        rd_valid_r;
    logic [15:0] rd_data_r;
    logic        rd_tag_r;

    logic [15:0] addr_cap_s;
    logic        issue_s;
    logic        finish_s;
    logic        lo_cap_s;
    logic        bus_req_next_s;
    logic        bus_we_next_s;
    logic [15:0] bus_addr_next_s;
    logic [7:0]  bus_wdata_next_s;

    // A MAR write in the issue cycle is bypassed straight into the command.
    assign addr_cap_s = mar_wr ? mar_in : mar_r;

    // Next state and next bus-beat values; bus outputs hold unless a beat starts or ends.
    always_comb begin
        state_next_s     = state_r;
        issue_s          = 1'b0;
        finish_s         = 1'b0;
        lo_cap_s         = 1'b0;
        bus_req_next_s   = bus_req_r;
        bus_we_next_s    = bus_we_r;
        bus_addr_next_s  = bus_addr_r;
        bus_wdata_next_s = bus_wdata_r;
        case (state_r)
            MA_IDLE: begin
                if (mem_rq) begin
                    state_next_s     = MA_BEAT0;
                    issue_s          = 1'b1;
                    bus_req_next_s   = 1'b1;
                    bus_we_next_s    = mem_rq_cmd;
                    bus_addr_next_s  = addr_cap_s;
                    bus_wdata_next_s = wr_data[7:0];
                end else begin
                    state_next_s = MA_IDLE;
                end
            end
            MA_BEAT0: begin
                if (bus_ack) begin
                    lo_cap_s = 1'b1;
                    if (width_r == MEM_W_WORD) begin
                        state_next_s     = MA_BEAT1;
                        bus_addr_next_s  = ma_next_addr(addr_r);
                        bus_wdata_next_s = wdata_hi_r;
                    end else begin
                        state_next_s     = MA_IDLE;
                        finish_s         = 1'b1;
                        bus_req_next_s   = 1'b0;
                        bus_we_next_s    = 1'b0;
                        bus_addr_next_s  = 16'h0000;
                        bus_wdata_next_s = 8'h00;
                    end
                end else begin
                    state_next_s = MA_BEAT0;
                end
            end
            MA_BEAT1: begin
                if (bus_ack) begin
                    state_next_s     = MA_IDLE;
                    finish_s         = 1'b1;
                    bus_req_next_s   = 1'b0;
                    bus_we_next_s    = 1'b0;
                    bus_addr_next_s  = 16'h0000;
                    bus_wdata_next_s = 8'h00;
                end else begin
                    state_next_s = MA_BEAT1;
                end
            end
            default: begin
                state_next_s     = MA_IDLE;
                bus_req_next_s   = 1'b0;
                bus_we_next_s    = 1'b0;
                bus_addr_next_s  = 16'h0000;
                bus_wdata_next_s = 8'h00;
            end
        endcase
    end

    // State register, registered bus outputs and the Moore stall flag.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_r     <= MA_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 16'h0000;
            bus_wdata_r <= 8'h00;
            stop_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bus_req_r   <= bus_req_next_s;
            bus_we_r    <= bus_we_next_s;
            bus_addr_r  <= bus_addr_next_s;
            bus_wdata_r <= bus_wdata_next_s;
            stop_r      <= (state_next_s != MA_IDLE);
        end
    end

    // MAR and per-command capture; requests while busy never reach issue_s.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            mar_r      <= 16'h0000;
            addr_r     <= 16'h0000;
            cmd_r      <= MEM_CMD_READ;
            width_r    <= MEM_W_BYTE;
            wdata_hi_r <= 8'h00;
            tag_r      <= 1'b0;
            lo_byte_r  <= 8'h00;
        end else begin
            if (mar_wr) begin
                mar_r <= mar_in;
            end
            if (issue_s) begin
                addr_r     <= addr_cap_s;
                cmd_r      <= mem_rq_cmd;
                width_r    <= mem_rq_width;
                wdata_hi_r <= wr_data[15:8];
                tag_r      <= main_ex_mem;
            end
            if (lo_cap_s) begin
                lo_byte_r <= bus_rdata;
            end
        end
    end

    // Completion pulses and read result assembly (hi byte arrives on the finishing ack).
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 16'h0000;
            rd_tag_r   <= 1'b0;
        end else begin
            done_r     <= finish_s;
            rd_valid_r <= finish_s && (cmd_r == MEM_CMD_READ);
            if (finish_s && (cmd_r == MEM_CMD_READ)) begin
                rd_tag_r <= tag_r;
                if (state_r == MA_BEAT1) begin
                    rd_data_r <= {bus_rdata, lo_byte_r};
                end else begin
                    rd_data_r <= {8'h00, bus_rdata};
                end
            end
        end
    end

    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign stop      = stop_r;
    assign done      = done_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_tag    = rd_tag_r;

endmodule

// File: tb/tb_uop_mem_access.sv
// Directed bench for uop_mem_access: inputs change 1 time unit after the
// rising edge, outputs are sampled at the same point, so values read after a
// step belong to the cycle that edge started.
module tb_uop_mem_access;

    logic        clk;
    logic        a_rst;
    logic        mar_wr;
    logic [15:0] mar_in;
    logic        mem_rq;
    logic        mem_rq_cmd;
    logic        mem_rq_width;
    logic        main_ex_mem;
    logic [15:0] wr_data;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        stop;
    logic        done;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_tag;

    int vec_cnt;
    int err_cnt;

    uop_mem_access dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .mar_wr       (mar_wr),
        .mar_in       (mar_in),
        .mem_rq       (mem_rq),
        .mem_rq_cmd   (mem_rq_cmd),
        .mem_rq_width (mem_rq_width),
        .main_ex_mem  (main_ex_mem),
        .wr_data      (wr_data),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .stop         (stop),
        .done         (done),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_tag       (rd_tag)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".bus_req"},   {15'd0, bus_req},  16'h0000);
        check_val({tag, ".bus_we"},    {15'd0, bus_we},   16'h0000);
        check_val({tag, ".bus_addr"},  bus_addr,          16'h0000);
        check_val({tag, ".bus_wdata"}, {8'd0, bus_wdata}, 16'h0000);
        check_val({tag, ".stop"},      {15'd0, stop},     16'h0000);
        check_val({tag, ".done"},      {15'd0, done},     16'h0000);
        check_val({tag, ".rd_valid"},  {15'd0, rd_valid}, 16'h0000);
        check_val({tag, ".rd_data"},   rd_data,           16'h0000);
        check_val({tag, ".rd_tag"},    {15'd0, rd_tag},   16'h0000);
    endtask

    initial begin
        vec_cnt      = 0;
        err_cnt      = 0;
        a_rst        = 1'b0;
        mar_wr       = 1'b0;
        mar_in       = 16'h0000;
        mem_rq       = 1'b0;
        mem_rq_cmd   = 1'b0;
        mem_rq_width = 1'b0;
        main_ex_mem  = 1'b0;
        wr_data      = 16'h0000;
        bus_ack      = 1'b0;
        bus_rdata    = 8'h00;

        // Reset state
        #2;
        check_idle_outputs("rst");
        repeat (2) step();
        a_rst = 1'b1;
        step();

        // Byte read at 0x1234, zero wait; ack held high also while idle
        mar_wr = 1'b1; mar_in = 16'h1234;
        step();
        mar_wr = 1'b0;
        mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
        bus_ack = 1'b1; bus_rdata = 8'hAB;
        step();                                   // N+1
        mem_rq = 1'b0;
        check_val("br.req",  {15'd0, bus_req}, 16'h0001);
        check_val("br.stop", {15'd0, stop},    16'h0001);
        check_val("br.addr", bus_addr,         16'h1234);
        check_val("br.we",   {15'd0, bus_we},  16'h0000);
        check_val("br.done1",{15'd0, done},    16'h0000);
        step();                                   // N+2
        check_val("br.done",  {15'd0, done},     16'h0001);
        check_val("br.rdv",   {15'd0, rd_valid}, 16'h0001);
        check_val("br.data",  rd_data,           16'h00AB);
        check_val("br.stop2", {15'd0, stop},     16'h0000);
        check_val("br.req2",  {15'd0, bus_req},  16'h0000);
        step();                                   // N+3
        check_val("br.done3", {15'd0, done},     16'h0000);
        check_val("br.rdv3",  {15'd0, rd_valid}, 16'h0000);
        check_val("br.hold",  rd_data,           16'h00AB);

        // Word write with same-cycle MAR bypass at 0xFFFF (address wraps)
        mar_wr = 1'b1; mar_in = 16'hFFFF;
        mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b1; wr_data = 16'hBEEF;
        step();                                   // N+1
        mar_wr = 1'b0; mem_rq = 1'b0;
        check_val("ww.addr0",  bus_addr,          16'hFFFF);
        check_val("ww.wd0",    {8'd0, bus_wdata}, 16'h00EF);
        check_val("ww.we0",    {15'd0, bus_we},   16'h0001);
        check_val("ww.req0",   {15'd0, bus_req},  16'h0001);
        step();                                   // N+2
        check_val("ww.addr1",  bus_addr,          16'h0000);
        check_val("ww.wd1",    {8'd0, bus_wdata}, 16'h00BE);
        check_val("ww.we1",    {15'd0, bus_we},   16'h0001);
        check_val("ww.req1",   {15'd0, bus_req},  16'h0001);
        check_val("ww.done1",  {15'd0, done},     16'h0000);
        step();                                   // N+3
        check_val("ww.done",   {15'd0, done},     16'h0001);
        check_val("ww.rdv",    {15'd0, rd_valid}, 16'h0000);
        check_val("ww.stop",   {15'd0, stop},     16'h0000);
        check_val("ww.rdhold", rd_data,           16'h00AB);

        // Word read at 0x2000, three wait cycles per beat, tag 1
        bus_ack = 1'b0;
        mar_wr = 1'b1; mar_in = 16'h2000;
        step();
        mar_wr = 1'b0;
        mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1; main_ex_mem = 1'b1;
        wr_data = 16'h0000;
        step();                                   // N+1
        mem_rq = 1'b0; main_ex_mem = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_val($sformatf("wr.req%0d", k),  {15'd0, bus_req}, 16'h0001);
            check_val($sformatf("wr.stop%0d", k), {15'd0, stop},    16'h0001);
            check_val($sformatf("wr.addr%0d", k), bus_addr, (k <= 4) ? 16'h2000 : 16'h2001);
            check_val($sformatf("wr.we%0d", k),   {15'd0, bus_we},  16'h0000);
            check_val($sformatf("wr.done%0d", k), {15'd0, done},    16'h0000);
            bus_ack   = (k == 4) || (k == 8);
            bus_rdata = (k == 4) ? 8'h34 : ((k == 8) ? 8'h12 : 8'hEE);
            step();
        end                                       // now N+9
        bus_ack = 1'b0;
        check_val("wr.done", {15'd0, done},     16'h0001);
        check_val("wr.rdv",  {15'd0, rd_valid}, 16'h0001);
        check_val("wr.data", rd_data,           16'h1234);
        check_val("wr.tag",  {15'd0, rd_tag},   16'h0001);
        check_val("wr.stop", {15'd0, stop},     16'h0000);

        // Request while busy is ignored; MAR write during BEAT0 only affects the next command
        mar_wr = 1'b1; mar_in = 16'h0100;
        step();
        mar_wr = 1'b0;
        mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
        step();                                   // N+1, BEAT0 waiting
        mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b1; wr_data = 16'hFFFF;
        mar_wr = 1'b1; mar_in = 16'h5555;
        step();                                   // N+2
        mem_rq = 1'b0; mar_wr = 1'b0;
        check_val("bz.addr", bus_addr,        16'h0100);
        check_val("bz.we",   {15'd0, bus_we}, 16'h0000);
        check_val("bz.req",  {15'd0, bus_req},16'h0001);
        bus_ack = 1'b1; bus_rdata = 8'h77;
        step();
        check_val("bz.done", {15'd0, done},     16'h0001);
        check_val("bz.rdv",  {15'd0, rd_valid}, 16'h0001);
        check_val("bz.data", rd_data,           16'h0077);
        check_val("bz.tag",  {15'd0, rd_tag},   16'h0000);
        bus_ack = 1'b0;
        mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
        step();
        mem_rq = 1'b0;
        check_val("bz.maraddr", bus_addr,        16'h5555);
        check_val("bz.mardone", {15'd0, done},   16'h0000);
        bus_ack = 1'b1; bus_rdata = 8'h66;
        step();
        check_val("bz.data2", rd_data,          16'h0066);
        check_val("bz.done2", {15'd0, done},    16'h0001);

        // Back-to-back byte reads, second request in the done cycle
        mem_rq = 1'b1; bus_rdata = 8'h11;
        step();                                   // c1
        mem_rq = 1'b0;
        check_val("bb.req1",  {15'd0, bus_req}, 16'h0001);
        check_val("bb.done1", {15'd0, done},    16'h0000);
        step();                                   // c2
        check_val("bb.done2", {15'd0, done},    16'h0001);
        check_val("bb.data2", rd_data,          16'h0011);
        mem_rq = 1'b1; bus_rdata = 8'h22;
        step();                                   // c3
        mem_rq = 1'b0;
        check_val("bb.done3", {15'd0, done},    16'h0000);
        check_val("bb.req3",  {15'd0, bus_req}, 16'h0001);
        check_val("bb.stop3", {15'd0, stop},    16'h0001);
        step();                                   // c4
        check_val("bb.done4", {15'd0, done},    16'h0001);
        check_val("bb.data4", rd_data,          16'h0022);
        step();                                   // c5
        check_val("bb.done5", {15'd0, done},    16'h0000);
        check_val("bb.req5",  {15'd0, bus_req}, 16'h0000);

        // Reset asserted mid-BEAT1 of a word read
        mar_wr = 1'b1; mar_in = 16'h3000;
        mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
        bus_ack = 1'b1; bus_rdata = 8'hAA;
        step();                                   // BEAT0
        mar_wr = 1'b0; mem_rq = 1'b0;
        step();                                   // BEAT1
        check_val("ra.addr1", bus_addr, 16'h3001);
        bus_ack = 1'b0;
        #2;
        a_rst = 1'b0;
        #1;
        check_idle_outputs("ra");
        #1;
        a_rst = 1'b1;
        bus_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("ra.done%0d", k), {15'd0, done},    16'h0000);
            check_val($sformatf("ra.stop%0d", k), {15'd0, stop},    16'h0000);
            check_val($sformatf("ra.req%0d", k),  {15'd0, bus_req}, 16'h0000);
        end
        // MAR was cleared by reset
        mem_rq = 1'b1; mem_rq_width = 1'b0;
        step();
        mem_rq = 1'b0;
        check_val("ra.maraddr", bus_addr, 16'h0000);
        step();
        check_val("ra.newdone", {15'd0, done}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
